// File: rtl/layer_seq_pkg.sv
// layer_seq shared types: scheduler states, program depth and layer opcodes.
// Imported by the interface, the program file and the sequencer top.
package layer_seq_pkg;

    localparam int MAX_LAYERS = 8;
    localparam int CLOG2ML    = $clog2(MAX_LAYERS);

    localparam logic [2:0] OP_CONV1 = 3'b000;
    localparam logic [2:0] OP_CONV2 = 3'b001;
    localparam logic [2:0] OP_FC    = 3'b100;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        SETUP,
        START,
        WAIT,
        NEXT,
        FIN
    } layer_seq_state_t;

endpackage

// File: rtl/layer_seq_if.sv
// Bus between a controller and layer_seq: program port, launch and fsm link.
// o_err exists only when LAYER_SEQ_TMO_EN is defined.
interface layer_seq_if;
    import layer_seq_pkg::*;

    logic               i_prog_we;
    logic [CLOG2ML-1:0] i_prog_addr;
    logic [2:0]         i_prog_opcode;
    logic [CLOG2ML:0]   i_nb_layers;
    logic               i_go;
    logic               i_fsm_done;
    logic               o_fsm_start;
    logic               o_soft_rst;
    logic [2:0]         o_opcode;
    logic               o_bank_sel;
    logic [CLOG2ML-1:0] o_layer_idx;
    logic               o_busy;
    logic               o_done;
`ifdef LAYER_SEQ_TMO_EN
    logic               o_err;
`endif

    modport master (
        output i_prog_we, i_prog_addr, i_prog_opcode,
        output i_nb_layers, i_go, i_fsm_done,
        input  o_fsm_start, o_soft_rst, o_opcode, o_bank_sel,
        input  o_layer_idx, o_busy, o_done
`ifdef LAYER_SEQ_TMO_EN
        , input o_err
`endif
    );

    modport slave (
        input  i_prog_we, i_prog_addr, i_prog_opcode,
        input  i_nb_layers, i_go, i_fsm_done,
        output o_fsm_start, o_soft_rst, o_opcode, o_bank_sel,
        output o_layer_idx, o_busy, o_done
`ifdef LAYER_SEQ_TMO_EN
        , output o_err
`endif
    );

endinterface

// File: rtl/layer_seq_prog.sv
// Layer opcode program: MAX_LAYERS x 3-bit registers, one write port,
// one combinational read port, cleared by the asynchronous reset.
module layer_seq_prog #(
    parameter int MAX_LAYERS = layer_seq_pkg::MAX_LAYERS,
    parameter int AW         = $clog2(MAX_LAYERS)
) (
    input  logic          ck,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [2:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [2:0]    rdata
);

    logic [2:0] mem [MAX_LAYERS];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LAYERS; i++) begin
                mem[i] <= 3'b000;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/layer_seq.sv
// Multi-layer scheduler driving the convolution fsm/cfg/dp trio.
// Optional watchdog with o_err: define LAYER_SEQ_TMO_EN.
module layer_seq #(
    parameter int MAX_LAYERS = layer_seq_pkg::MAX_LAYERS,
    parameter int SRST_CYC   = 2,
    parameter int SETUP_CYC  = 2
`ifdef LAYER_SEQ_TMO_EN
    , parameter int TMO_CYC  = 65536
`endif
) (
    input  logic        ck,
    input  logic        rst,
    layer_seq_if.slave  bus
);
    import layer_seq_pkg::*;

    localparam int AW   = $clog2(MAX_LAYERS);
    localparam int NW   = AW + 1;
    localparam int CMAX = (SRST_CYC > SETUP_CYC) ? SRST_CYC : SETUP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    layer_seq_state_t state;

    logic [CW-1:0] cnt;
    logic [AW-1:0] idx;
    logic [NW-1:0] nb;
    logic [NW-1:0] nb_in;
    logic [2:0]    opcode;
    logic [2:0]    rd_op;
    logic          bank;
    logic          start;
    logic          srst;
    logic          busy;
    logic          done;
    logic          done_q;
    logic          done_rise;
    logic          last;
    logic          prog_we;

`ifdef LAYER_SEQ_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] wcnt;
    logic          err;
    logic          abort;
`endif

    assign nb_in = (bus.i_nb_layers > NW'(MAX_LAYERS))
                 ? NW'(MAX_LAYERS) : bus.i_nb_layers;

    assign prog_we   = bus.i_prog_we && (state == IDLE);
    assign done_rise = bus.i_fsm_done && !done_q;
    assign last      = ({1'b0, idx} == (nb - NW'(1)));

    layer_seq_prog #(
        .MAX_LAYERS (MAX_LAYERS),
        .AW         (AW)
    ) u_prog (
        .ck    (ck),
        .rst   (rst),
        .we    (prog_we),
        .waddr (bus.i_prog_addr),
        .wdata (bus.i_prog_opcode),
        .raddr (idx),
        .rdata (rd_op)
    );

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            nb     <= '0;
            opcode <= 3'b000;
            bank   <= 1'b0;
            start  <= 1'b0;
            srst   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            done_q <= 1'b0;
`ifdef LAYER_SEQ_TMO_EN
            wcnt   <= '0;
            err    <= 1'b0;
            abort  <= 1'b0;
`endif
        end else begin
            done_q <= bus.i_fsm_done;
            start  <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_go) begin
                        nb   <= nb_in;
                        idx  <= '0;
                        bank <= 1'b0;
                        busy <= 1'b1;
                        cnt  <= '0;
`ifdef LAYER_SEQ_TMO_EN
                        err  <= 1'b0;
`endif
                        if (nb_in == '0) begin
                            state <= FIN;
                        end else begin
                            state <= CLR;
                            srst  <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    if (cnt == CW'(SRST_CYC - 1)) begin
                        cnt    <= '0;
                        srst   <= 1'b0;
                        state  <= SETUP;
                        opcode <= rd_op;
`ifdef LAYER_SEQ_TMO_EN
                        // watchdog clear finished: back to IDLE, no done
                        if (abort) begin
                            abort  <= 1'b0;
                            busy   <= 1'b0;
                            state  <= IDLE;
                            opcode <= opcode;
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SETUP: begin
                    if (cnt == CW'(SETUP_CYC - 1)) begin
                        cnt   <= '0;
                        state <= START;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                START: begin
                    start <= 1'b1;
                    state <= WAIT;
`ifdef LAYER_SEQ_TMO_EN
                    wcnt  <= '0;
`endif
                end
                WAIT: begin
                    if (done_rise) begin
                        bank  <= ~bank;
                        state <= NEXT;
                    end
`ifdef LAYER_SEQ_TMO_EN
                    else if (wcnt == TW'(TMO_CYC - 1)) begin
                        err   <= 1'b1;
                        abort <= 1'b1;
                        srst  <= 1'b1;
                        cnt   <= '0;
                        state <= CLR;
                    end else begin
                        wcnt <= wcnt + TW'(1);
                    end
`endif
                end
                NEXT: begin
                    if (last) begin
                        state <= FIN;
                    end else begin
                        idx   <= idx + AW'(1);
                        srst  <= 1'b1;
                        state <= CLR;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_fsm_start = start;
    assign bus.o_soft_rst  = srst;
    assign bus.o_opcode    = opcode;
    assign bus.o_bank_sel  = bank;
    assign bus.o_layer_idx = idx;
    assign bus.o_busy      = busy;
    assign bus.o_done      = done;
`ifdef LAYER_SEQ_TMO_EN
    assign bus.o_err       = err;
`endif

endmodule

// File: tb/tb_layer_seq.sv
// Directed bench for layer_seq: vector table of whole programs plus
// hand sequences for timing, done edges, busy-time inputs, reset, watchdog.
module tb_layer_seq;

`ifdef LAYER_SEQ_TMO_EN
    localparam int D50  = 10;
    localparam int HOLD = 3;
    localparam int LOW  = 6;
    localparam int RDLY = 8;
`else
    localparam int D50  = 50;
    localparam int HOLD = 5;
    localparam int LOW  = 10;
    localparam int RDLY = 20;
`endif

    logic ck;
    logic rst;
    int   checks;
    int   failures;
    logic [2:0] model [8];

    layer_seq_if bus ();

    layer_seq #(
        .SRST_CYC  (2),
        .SETUP_CYC (2)
`ifdef LAYER_SEQ_TMO_EN
        , .TMO_CYC (16)
`endif
    ) dut (
        .ck  (ck),
        .rst (rst),
        .bus (bus)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #600000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input int addr, input logic [2:0] op);
        bus.i_prog_we     = 1'b1;
        bus.i_prog_addr   = addr[2:0];
        bus.i_prog_opcode = op;
        tick();
        bus.i_prog_we     = 1'b0;
        model[addr]       = op;
    endtask

    task automatic go(input logic [3:0] nb);
        bus.i_nb_layers = nb;
        bus.i_go        = 1'b1;
        tick();
        bus.i_go        = 1'b0;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while (!bus.o_fsm_start && k < 100) begin
            tick();
            k++;
        end
        chk("start_seen", bus.o_fsm_start, 1'b1);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!bus.o_done && k < 100) begin
            tick();
            k++;
        end
        chk("done_seen", bus.o_done, 1'b1);
    endtask

    task automatic pulse_done();
        bus.i_fsm_done = 1'b1;
        tick();
        bus.i_fsm_done = 1'b0;
    endtask

    // Full program run with an fsm model answering each start after dly.
    task automatic run(input logic [3:0] nb, input int dly,
                       input bit wr0, input logic [2:0] op0,
                       output int ns, output int nd);
        int pend;
        int cyc;
        pend = 0;
        cyc  = 0;
        ns   = 0;
        nd   = 0;
        bus.i_fsm_done = 1'b0;
        if (wr0) begin
            bus.i_prog_we     = 1'b1;
            bus.i_prog_addr   = 3'd0;
            bus.i_prog_opcode = op0;
            model[0]          = op0;
        end
        go(nb);
        bus.i_prog_we = 1'b0;
        while (nd == 0 && cyc < 4000) begin
            bus.i_fsm_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) bus.i_fsm_done = 1'b1;
            end
            if (bus.o_fsm_start) begin
                ns++;
                chk("opcode", bus.o_opcode, model[bus.o_layer_idx]);
                chk("bank_in", bus.o_bank_sel, bus.o_layer_idx[0]);
                pend = dly;
            end
            if (bus.o_done) begin
                nd++;
                chk("busy_at_done", bus.o_busy, 1'b0);
            end
            tick();
            cyc++;
        end
        bus.i_fsm_done = 1'b0;
    endtask

    typedef struct {
        logic [3:0] nb;
        int         dly;
        int         exp_ns;
        logic       exp_bank;
    } vec_t;

    vec_t v [7];

    initial begin
        int ns;
        int nd;
        int k;
        int hi;
        int extra;
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 8; i++) model[i] = 3'b000;

        v[0] = '{4'd1,  4,   1, 1'b1};
        v[1] = '{4'd2,  D50, 2, 1'b0};
        v[2] = '{4'd3,  1,   3, 1'b1};
        v[3] = '{4'd8,  2,   8, 1'b0};
        v[4] = '{4'd12, 3,   8, 1'b0};
        v[5] = '{4'd15, 1,   8, 1'b0};
        v[6] = '{4'd7,  5,   7, 1'b1};

        rst               = 1'b1;
        bus.i_prog_we     = 1'b0;
        bus.i_prog_addr   = '0;
        bus.i_prog_opcode = '0;
        bus.i_nb_layers   = '0;
        bus.i_go          = 1'b0;
        bus.i_fsm_done    = 1'b0;
        tick();
        tick();
        chk("rst_start", bus.o_fsm_start, 1'b0);
        chk("rst_srst", bus.o_soft_rst, 1'b0);
        chk("rst_opcode", bus.o_opcode, 3'b000);
        chk("rst_bank", bus.o_bank_sel, 1'b0);
        chk("rst_idx", bus.o_layer_idx, 3'd0);
        chk("rst_busy", bus.o_busy, 1'b0);
        chk("rst_done", bus.o_done, 1'b0);
        rst = 1'b0;
        tick();

        wr(0, 3'b000);
        wr(1, 3'b001);
        wr(2, 3'b100);
        wr(3, 3'b001);
        wr(4, 3'b000);
        wr(5, 3'b100);
        wr(6, 3'b001);
        wr(7, 3'b100);

        for (int i = 0; i < 7; i++) begin
            run(v[i].nb, v[i].dly, 1'b0, 3'b000, ns, nd);
            chk("starts", ns, v[i].exp_ns);
            chk("done_cnt", nd, 1);
            chk("bank_end", bus.o_bank_sel, v[i].exp_bank);
            chk("busy_end", bus.o_busy, 1'b0);
        end

        // write and go in the same cycle: new opcode is used
        run(4'd1, 2, 1'b1, 3'b110, ns, nd);
        chk("wrgo_starts", ns, 1);
        chk("wrgo_done", nd, 1);

        // zero layers: done two edges after go, no start, no clear
        go(4'd0);
        chk("nb0_busy", bus.o_busy, 1'b1);
        chk("nb0_done1", bus.o_done, 1'b0);
        extra = int'(bus.o_fsm_start) + int'(bus.o_soft_rst);
        tick();
        chk("nb0_done2", bus.o_done, 1'b1);
        extra += int'(bus.o_fsm_start) + int'(bus.o_soft_rst);
        chk("nb0_quiet", extra, 0);
        tick();

        // clear width and start latency after the clear falls
        go(4'd1);
        hi = 0;
        while (bus.o_soft_rst && hi < 20) begin
            hi++;
            tick();
        end
        chk("srst_width", hi, 2);
        k = 0;
        while (!bus.o_fsm_start && k < 20) begin
            k++;
            tick();
        end
        chk("start_lat", k, 3);
        pulse_done();
        wait_done();
        tick();

        // done already high at WAIT entry must not count
        bus.i_fsm_done = 1'b1;
        go(4'd1);
        wait_start();
        repeat (HOLD) tick();
        bus.i_fsm_done = 1'b0;
        repeat (LOW) tick();
        chk("held_bank", bus.o_bank_sel, 1'b0);
        chk("held_busy", bus.o_busy, 1'b1);
        bus.i_fsm_done = 1'b1;
        wait_done();
        chk("held_bank_end", bus.o_bank_sel, 1'b1);
        bus.i_fsm_done = 1'b0;
        tick();

        // write and go while busy are dropped
        go(4'd1);
        wait_start();
        bus.i_prog_we     = 1'b1;
        bus.i_prog_addr   = 3'd0;
        bus.i_prog_opcode = 3'b111;
        bus.i_nb_layers   = 4'd3;
        bus.i_go          = 1'b1;
        tick();
        bus.i_prog_we = 1'b0;
        bus.i_go      = 1'b0;
        pulse_done();
        extra = 0;
        k = 0;
        while (!bus.o_done && k < 100) begin
            if (bus.o_fsm_start) extra++;
            tick();
            k++;
        end
        chk("busy_done", bus.o_done, 1'b1);
        chk("busy_extra_starts", extra, 0);
        chk("busy_bank", bus.o_bank_sel, 1'b1);
        tick();
        run(4'd1, 2, 1'b0, 3'b000, ns, nd);
        chk("busy_prog_kept", ns, 1);

        // reset in WAIT of layer 1
        wr(0, 3'b001);
        wr(1, 3'b100);
        go(4'd2);
        wait_start();
        pulse_done();
        wait_start();
        repeat (RDLY) tick();
        rst = 1'b1;
        #1;
        chk("arst_start", bus.o_fsm_start, 1'b0);
        chk("arst_srst", bus.o_soft_rst, 1'b0);
        chk("arst_opcode", bus.o_opcode, 3'b000);
        chk("arst_bank", bus.o_bank_sel, 1'b0);
        chk("arst_idx", bus.o_layer_idx, 3'd0);
        chk("arst_busy", bus.o_busy, 1'b0);
        chk("arst_done", bus.o_done, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 3'b000;
        tick();
        run(4'd2, 2, 1'b0, 3'b000, ns, nd);
        chk("arst_rerun", ns, 2);

`ifdef LAYER_SEQ_TMO_EN
        // watchdog: done never comes
        bus.i_fsm_done = 1'b0;
        go(4'd1);
        wait_start();
        k = 0;
        while (!bus.o_err && k < 40) begin
            tick();
            k++;
        end
        chk("tmo_lat", k, 16);
        hi = 0;
        while (bus.o_soft_rst && hi < 10) begin
            hi++;
            tick();
        end
        chk("tmo_srst", hi, 2);
        chk("tmo_idle", bus.o_busy, 1'b0);
        nd = 0;
        repeat (5) begin
            if (bus.o_done) nd++;
            tick();
        end
        chk("tmo_no_done", nd, 0);
        chk("tmo_err_sticky", bus.o_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
